// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite response codes and initiator state encoding
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RD,
        RR,
        RESP
    } axil_mst_state_e;

endpackage

// File: rtl/axi_lite_master_if.sv
// rtl/axi_lite_master_if.sv - AXI4-Lite bus bundle with initiator and target views
interface axi_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite initiator behind a cmd/rsp port
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_W-1:0]     cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    axi_lite_master_if.master     axi
);

    localparam int OFFS = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFS;

    axil_mst_state_e       state_q, state_n;
    logic                  aw_done_q, aw_done_n;
    logic                  w_done_q, w_done_n;
    logic                  cmd_ready_q, cmd_ready_n;
    logic                  rsp_valid_q, rsp_valid_n;
    logic                  rsp_write_q, rsp_write_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_n;
    axi_resp_e             rsp_resp_q, rsp_resp_n;
    logic                  awvalid_q, awvalid_n;
    logic                  wvalid_q, wvalid_n;
    logic                  bready_q, bready_n;
    logic                  arvalid_q, arvalid_n;
    logic                  rready_q, rready_n;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_n;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [STRB_W-1:0]     wstrb_q, wstrb_n;

    // Next state and next value of every registered output, so all outputs come straight from flops
    always_comb begin
        state_n     = state_q;
        aw_done_n   = aw_done_q;
        w_done_n    = w_done_q;
        cmd_ready_n = cmd_ready_q;
        rsp_valid_n = rsp_valid_q;
        rsp_write_n = rsp_write_q;
        rsp_rdata_n = rsp_rdata_q;
        rsp_resp_n  = rsp_resp_q;
        awvalid_n   = awvalid_q;
        wvalid_n    = wvalid_q;
        bready_n    = bready_q;
        arvalid_n   = arvalid_q;
        rready_n    = rready_q;
        awaddr_n    = awaddr_q;
        araddr_n    = araddr_q;
        wdata_n     = wdata_q;
        wstrb_n     = wstrb_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_n = 1'b0;
                    if (cmd_write) begin
                        state_n   = WR;
                        awaddr_n  = cmd_addr & ADDR_MASK;
                        wdata_n   = cmd_wdata;
                        wstrb_n   = cmd_wstrb;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
                    end else begin
                        state_n   = RD;
                        araddr_n  = cmd_addr & ADDR_MASK;
                        arvalid_n = 1'b1;
                    end
                end
            end
            WR: begin
                if (awvalid_q && axi.awready) begin
                    awvalid_n = 1'b0;
                    aw_done_n = 1'b1;
                end
                if (wvalid_q && axi.wready) begin
                    wvalid_n = 1'b0;
                    w_done_n = 1'b1;
                end
                if (aw_done_n && w_done_n) begin
                    state_n  = WB;
                    bready_n = 1'b1;
                end
            end
            WB: begin
                if (axi.bvalid && bready_q) begin
                    bready_n    = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_write_n = 1'b1;
                    rsp_rdata_n = '0;
                    rsp_resp_n  = axi_resp_e'(axi.bresp);
                    state_n     = RESP;
                end
            end
            RD: begin
                if (arvalid_q && axi.arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RR;
                end
            end
            RR: begin
                if (axi.rvalid && rready_q) begin
                    rready_n    = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_write_n = 1'b0;
                    rsp_rdata_n = axi.rdata;
                    rsp_resp_n  = axi_resp_e'(axi.rresp);
                    state_n     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every valid immediately and reopens the command port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_n;
            aw_done_q   <= aw_done_n;
            w_done_q    <= w_done_n;
            cmd_ready_q <= cmd_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_write_q <= rsp_write_n;
            rsp_rdata_q <= rsp_rdata_n;
            rsp_resp_q  <= rsp_resp_n;
            awvalid_q   <= awvalid_n;
            wvalid_q    <= wvalid_n;
            bready_q    <= bready_n;
            arvalid_q   <= arvalid_n;
            rready_q    <= rready_n;
            awaddr_q    <= awaddr_n;
            araddr_q    <= araddr_n;
            wdata_q     <= wdata_n;
            wstrb_q     <= wstrb_n;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule
